// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic phase sequencer: light codes, FSM states and the default 18-phase tables.
// The FLASH state exists only when TLC_FLASH_EN is defined.
package tlc_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [1:0] REDYEL = 2'b11;

  localparam int DEF_LANES  = 4;
  localparam int DEF_PHASES = 18;
  localparam int DEF_CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HOLD,
    ST_EMERG
`ifdef TLC_FLASH_EN
    , ST_FLASH
`endif
  } tlc_state_e;

  // Lane 0 (HS1) sits in the least significant bits of the packed code.
  function automatic logic [7:0] lanes4(input logic [1:0] hs1, input logic [1:0] hs2,
                                        input logic [1:0] ns1, input logic [1:0] ns2);
    return {ns2, ns1, hs2, hs1};
  endfunction

  localparam logic [0:DEF_PHASES-1][DEF_CNT_W-1:0] DEF_DUR = '{
    5'd1, 5'd1, 5'd30, 5'd2, 5'd10, 5'd2, 5'd1, 5'd2, 5'd15,
    5'd2, 5'd5, 5'd2,  5'd10, 5'd2, 5'd1, 5'd2, 5'd15, 5'd3
  };

  localparam logic [0:DEF_PHASES-1][2*DEF_LANES-1:0] DEF_CODE = '{
    lanes4(RED,    RED,    RED,    RED),
    lanes4(REDYEL, REDYEL, RED,    RED),
    lanes4(GREEN,  GREEN,  RED,    RED),
    lanes4(GREEN,  YELLOW, RED,    RED),
    lanes4(GREEN,  RED,    RED,    RED),
    lanes4(YELLOW, RED,    RED,    RED),
    lanes4(RED,    RED,    RED,    RED),
    lanes4(RED,    RED,    REDYEL, REDYEL),
    lanes4(RED,    RED,    GREEN,  GREEN),
    lanes4(RED,    RED,    YELLOW, YELLOW),
    lanes4(RED,    RED,    GREEN,  RED),
    lanes4(RED,    RED,    YELLOW, RED),
    lanes4(RED,    RED,    RED,    GREEN),
    lanes4(RED,    RED,    RED,    YELLOW),
    lanes4(RED,    RED,    RED,    RED),
    lanes4(REDYEL, RED,    RED,    RED),
    lanes4(GREEN,  RED,    RED,    RED),
    lanes4(YELLOW, RED,    RED,    RED)
  };

endpackage

// File: rtl/tlc_tick_gen.sv
// Tick prescaler: counts enabled CLK cycles 0..TICK_DIV-1 and strobes tick on the last count.
// A disabled prescaler holds its count so a paused partial tick resumes where it stopped.
module tlc_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Table-driven traffic-light phase sequencer with tick prescaler, GO hold and emergency all-red override.
// Define TLC_FLASH_EN to add the FLASH input and the flashing-yellow state.
module traffic_phase_sequencer
  import tlc_pkg::*;
#(
  parameter int NUM_LANES  = DEF_LANES,
  parameter int NUM_PHASES = DEF_PHASES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TICK_DIV   = 1,
  parameter logic [0:NUM_PHASES-1][CNT_W-1:0]       DUR_TAB  = DEF_DUR,
  parameter logic [0:NUM_PHASES-1][2*NUM_LANES-1:0] CODE_TAB = DEF_CODE,
  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   GO,
  input  logic                   EMERG,
`ifdef TLC_FLASH_EN
  input  logic                   FLASH,
`endif
  output logic [2*NUM_LANES-1:0] LIGHTS,
  output logic [PH_W-1:0]        PHASE,
  output logic                   CYCLE_DONE,
  output logic                   EMERG_ACT
);

  localparam logic [2*NUM_LANES-1:0] ALL_RED = {NUM_LANES{RED}};
  localparam logic [PH_W-1:0]        LAST_PH = PH_W'(NUM_PHASES - 1);

  tlc_state_e            state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*NUM_LANES-1:0] lights_q, lights_d;
  logic                  done_q, done_d;
  logic                  tick_en, tick, presc_clr;

`ifdef TLC_FLASH_EN
  localparam logic [2*NUM_LANES-1:0] ALL_YEL = {NUM_LANES{YELLOW}};
  logic toggle_q, toggle_d;

  assign tick_en = !EMERG && (FLASH ? (state_q == ST_FLASH) : (GO && state_q == ST_RUN));
`else
  assign tick_en = !EMERG && GO && (state_q == ST_RUN);
`endif

  tlc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .en   (tick_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred on any path.
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    lights_d  = lights_q;
    done_d    = 1'b0;
    presc_clr = 1'b0;
`ifdef TLC_FLASH_EN
    toggle_d  = toggle_q;
`endif

    if (EMERG) begin
      // Whatever remained of the current phase is discarded.
      state_d   = ST_EMERG;
      phase_d   = '0;
      cnt_d     = '0;
      lights_d  = ALL_RED;
      presc_clr = 1'b1;
`ifdef TLC_FLASH_EN
      toggle_d  = 1'b0;
`endif
    end
`ifdef TLC_FLASH_EN
    else if (FLASH) begin
      state_d = ST_FLASH;
      if (state_q != ST_FLASH) begin
        toggle_d = 1'b0;
        lights_d = ALL_RED;
      end else if (tick) begin
        toggle_d = !toggle_q;
        lights_d = toggle_q ? ALL_RED : ALL_YEL;
      end
    end
`endif
    else begin
      unique case (state_q)
        ST_RUN: begin
          if (!GO) begin
            state_d = ST_HOLD;
          end else if (tick) begin
            if (cnt_q < DUR_TAB[phase_q]) begin
              cnt_d = cnt_q + 1'b1;
            end else begin
              cnt_d = '0;
              if (phase_q == LAST_PH) begin
                phase_d = '0;
                done_d  = 1'b1;
              end else begin
                phase_d = phase_q + 1'b1;
              end
              lights_d = CODE_TAB[phase_d];
            end
          end
        end
        ST_HOLD:  if (GO) state_d = ST_RUN;
        ST_EMERG: state_d = GO ? ST_RUN : ST_HOLD;
`ifdef TLC_FLASH_EN
        ST_FLASH: begin
          state_d   = ST_RUN;
          phase_d   = '0;
          cnt_d     = '0;
          lights_d  = CODE_TAB[0];
          presc_clr = 1'b1;
        end
`endif
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_RUN;
      phase_q  <= '0;
      cnt_q    <= '0;
      lights_q <= ALL_RED;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      lights_q <= lights_d;
      done_q   <= done_d;
    end
  end

`ifdef TLC_FLASH_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) toggle_q <= 1'b0;
    else     toggle_q <= toggle_d;
  end
`endif

  assign LIGHTS     = lights_q;
  assign PHASE      = phase_q;
  assign CYCLE_DONE = done_q;
  assign EMERG_ACT  = (state_q == ST_EMERG);

endmodule
